aes_key_sched: RTL and testbench
================================

# aes_key_sched

Parametrised AES round-key generator and store, successor to the AES-128-only key memory. It expands a 128- or 256-bit cipher key into 11 or 15 round keys. Key length is selected per `init` at run time; AES-256 support is removed at elaboration when not needed. It sits beside the encipher/decipher datapath, borrowing one external 32-bit S-box lane, and serves round keys through a combinational read port.

## Interface
- `AES256_EN`, default 1: 1 enables AES-256 mode; 0 forces `keylen` to 0 and sizes the store at 11 entries.
- `clk` input, 1 bit: sole clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `key` input, 256 bits: cipher key. AES-128 uses `key[255:128]`; AES-256 uses all bits, MSB first.
- `keylen` input, 1 bit: 0 selects AES-128, 1 selects AES-256. Sampled with `init`.
- `init` input, 1 bit: single-cycle start pulse.
- `round` input, 4 bits: round-key read index.
- `round_key` output, 128 bits: `key_mem[round]`, combinational.
- `ready` output, 1 bit: high when all round keys for the last accepted `init` are valid.
- `sboxw` output, 32 bits: word sent to the external S-box.
- `new_sboxw` input, 32 bits: S-box result for `sboxw`, same cycle (combinational).

## Operation
- Registers: `key_reg` (256), `keylen_reg`, `rcon_reg` (8), `round_ctr` (4), `state` (IDLE/GEN), `ready_reg`, and a store of 15 × 128 bits (11 × 128 when `AES256_EN=0`).
- `init=1` in any state latches `key`, `keylen` (masked by `AES256_EN`), `round_ctr<=0`, `rcon_reg<=8'h01`, `ready<=0`, `state<=GEN`.
  - `init` during GEN aborts the current expansion and restarts it. Partially written keys are not cleared.
- Last round `R` is 10 for AES-128 and 14 for AES-256. Each GEN cycle writes `key_mem[round_ctr]`, then `round_ctr` increments.
- On the cycle that writes round `R`: `state<=IDLE`, `ready<=1`.
- Round-key generation, with `p1` = previous round key, `p2` = key two rounds back, `w3` = `p1[31:0]`, `sboxw=w3`:
  - AES-128, ctr 0: `key_reg[255:128]`.
  - AES-128, ctr ≥ 1: `t = RotWord(new_sboxw) ^ {rcon,24'h0}`, where RotWord = `{s[23:0],s[31:24]}`. Then `k0=p1.w0^t`, `k1=p1.w1^k0`, `k2=p1.w2^k1`, `k3=p1.w3^k2`. rcon advances.
  - AES-256, ctr 0: `key_reg[255:128]`. ctr 1: `key_reg[127:0]`.
  - AES-256, even ctr ≥ 2: `t` as above, chained XOR starting from `p2`. rcon advances.
  - AES-256, odd ctr ≥ 3: `t = new_sboxw`, no rotation and no rcon, chained XOR starting from `p2`. rcon holds.
- rcon advance is GF(2^8) doubling: `{r[6:0],1'b0} ^ (8'h1b & {8{r[7]}})`.
- Read port:
  - `round_key = key_mem[round]` when `round ≤ R` of the latched mode; otherwise `128'h0`.
  - Reads while `ready=0` return whatever is stored, with no guarantee of validity.
- Reset (`reset_n=0` at a clock edge): `state=IDLE`, `ready=0`, `round_ctr=0`, `rcon_reg=0`, all store entries 0, `key_reg=0`, `keylen_reg=0`.
  - Reset overrides a simultaneous `init`.
  - `sboxw` resets to 0 because the store is zeroed.

## Timing
- `init` sampled at edge E0 gives `ready=0` after E0. Round k is written at edge E(k+1).
- `ready` rises after edge E11 (AES-128) or E15 (AES-256): 11 or 15 cycles of latency.
- Throughput is one round key per cycle with no stalls. `new_sboxw` must settle within the same cycle.
- `ready` stays high in IDLE until the next `init` or reset.
- `key` and `keylen` may change freely after E0.
- Reset mid-GEN: the next cycle is IDLE with `ready=0`; no further writes occur.

## Test plan
- AES-128, FIPS-197 A.1 key `2b7e1516_28aed2a6_abf71588_09cf4f3c` in `key[255:128]`: `ready` rises 11 cycles after `init`. round 1 = `a0fafe17_88542cb1_23a33939_2a6c7605`; round 10 = `d014f9a8_c9ee2589_e13f0cc8_b6630ca6`; round 11 = 0.
- AES-256, FIPS-197 A.3 key `603deb10…0914dff4`: `ready` rises after 15 cycles. round 1 = `1f352c07_3b6108d7_2d9810a3_0914dff4`; round 2 = `9ba35411_8e6925af_a51a8b5f_2067fcde`; round 14 = `fe4890d1_e6188d0b_046df344_706c631e`.
- Re-init with the AES-128 key issued 5 cycles into AES-256 generation: `ready` rises exactly 11 cycles after the second `init`; round 10 matches A.1.
- With `AES256_EN=0`, `keylen=1` plus the A.1 key: behaves as AES-128 and `ready` rises after 11 cycles.
- `reset_n=0` asserted mid-generation together with `init`: next cycle `ready=0`, all rounds read 0, and no writes follow.
- Reads across both modes:
  - Back-to-back AES-128 then AES-256 runs: each `round` 0..14 matches its golden value.
  - `round=15` reads 0.

Source files
------------

// File: rtl/aes_key_sched.sv
// AES round-key generator and store: expands a 128/256-bit cipher key into 11 or 15 round keys,
// one key per cycle, using an external combinational S-box lane; round keys served combinationally.
module aes_key_sched #(
    parameter bit AES256_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);
    localparam int NUM_KEYS = AES256_EN ? 15 : 11;

    typedef enum logic {IDLE, GEN} state_t;

    state_t       state_q, state_d;
    logic [255:0] key_reg_q, key_reg_d;
    logic         keylen_q, keylen_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic         ready_q, ready_d;
    logic [127:0] key_mem_q [NUM_KEYS];
    logic [127:0] key_mem_d [NUM_KEYS];

    logic [3:0]   last_round;
    logic [3:0]   prev1_idx, prev2_idx;
    logic [127:0] prev1, prev2, base_key, new_key;
    logic [31:0]  temp_w, k0, k1, k2, k3;
    logic [7:0]   rcon_next;
    logic         use_rot, rcon_adv;

    assign last_round = keylen_q ? 4'd14 : 4'd10;
    assign prev1_idx  = round_ctr_q - 4'd1;
    assign prev2_idx  = round_ctr_q - 4'd2;

    // Out-of-range previous indices (ctr 0/1 wrap) read as zero so sboxw is 0 after reset.
    always_comb begin
        prev1 = '0;
        prev2 = '0;
        if (int'(prev1_idx) < NUM_KEYS) prev1 = key_mem_q[prev1_idx];
        if (int'(prev2_idx) < NUM_KEYS) prev2 = key_mem_q[prev2_idx];
    end

    assign sboxw = prev1[31:0];

    always_comb begin
        rcon_next = {rcon_q[6:0], 1'b0} ^ (8'h1b & {8{rcon_q[7]}});
        use_rot   = !keylen_q || !round_ctr_q[0];
        temp_w    = use_rot ? ({new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0}) : new_sboxw;
        base_key  = keylen_q ? prev2 : prev1;
        k0        = base_key[127:96] ^ temp_w;
        k1        = base_key[95:64]  ^ k0;
        k2        = base_key[63:32]  ^ k1;
        k3        = base_key[31:0]   ^ k2;
        if (round_ctr_q == 4'd0) begin
            new_key = key_reg_q[255:128];
        end else if (keylen_q && round_ctr_q == 4'd1) begin
            new_key = key_reg_q[127:0];
        end else begin
            new_key = {k0, k1, k2, k3};
        end
        rcon_adv = (round_ctr_q != 4'd0) && !(keylen_q && round_ctr_q[0]);
    end

    always_comb begin
        state_d     = state_q;
        key_reg_d   = key_reg_q;
        keylen_d    = keylen_q;
        rcon_d      = rcon_q;
        round_ctr_d = round_ctr_q;
        ready_d     = ready_q;
        key_mem_d   = key_mem_q;
        if (init) begin
            key_reg_d   = key;
            keylen_d    = keylen & AES256_EN;
            round_ctr_d = 4'd0;
            rcon_d      = 8'h01;
            ready_d     = 1'b0;
            state_d     = GEN;
        end else if (state_q == GEN) begin
            if (int'(round_ctr_q) < NUM_KEYS) key_mem_d[round_ctr_q] = new_key;
            round_ctr_d = round_ctr_q + 4'd1;
            if (rcon_adv) rcon_d = rcon_next;
            if (round_ctr_q == last_round) begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            key_reg_q   <= '0;
            keylen_q    <= 1'b0;
            rcon_q      <= 8'h00;
            round_ctr_q <= 4'd0;
            ready_q     <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) key_mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            key_reg_q   <= key_reg_d;
            keylen_q    <= keylen_d;
            rcon_q      <= rcon_d;
            round_ctr_q <= round_ctr_d;
            ready_q     <= ready_d;
            for (int i = 0; i < NUM_KEYS; i++) key_mem_q[i] <= key_mem_d[i];
        end
    end

    always_comb begin
        round_key = '0;
        if (round <= last_round && int'(round) < NUM_KEYS) round_key = key_mem_q[round];
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 key-expansion vectors and a bench-side S-box.
`timescale 1ns/1ps
module tb_aes_key_sched;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key, round_key_n;
    logic         ready, ready_n;
    logic [31:0]  sboxw, sboxw_n, new_sboxw, new_sboxw_n;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [255:0] KEY_A1 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    localparam logic [255:0] KEY_A3 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    localparam logic [127:0] A128 [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };
    localparam logic [127:0] A256_R0  = 128'h603deb10_15ca71be_2b73aef0_857d7781;
    localparam logic [127:0] A256_R1  = 128'h1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [127:0] A256_R2  = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
    localparam logic [127:0] A256_R14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

    logic [127:0] model_rk [15];

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    assign new_sboxw   = sub_word(sboxw);
    assign new_sboxw_n = sub_word(sboxw_n);

    aes_key_sched #(.AES256_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .key(key), .keylen(keylen), .init(init), .round(round),
        .round_key(round_key), .ready(ready), .sboxw(sboxw), .new_sboxw(new_sboxw)
    );

    aes_key_sched #(.AES256_EN(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .key(key), .keylen(keylen), .init(init), .round(round),
        .round_key(round_key_n), .ready(ready_n), .sboxw(sboxw_n), .new_sboxw(new_sboxw_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain FIPS-197 word-oriented KeyExpansion.
    task automatic build_model(input logic [255:0] k, input bit is256);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        int nk, nr;
        nk = is256 ? 8 : 4;
        nr = is256 ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 15; r++)
            model_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Pulses init (sampled at the next edge, E0) and checks ready dropped.
    task automatic start(input logic [255:0] k, input logic len);
        key = k;
        keylen = len;
        init = 1'b1;
        tick();
        init = 1'b0;
        key = '1;
        keylen = ~len;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_init: got %b expected 0", ready);
        end
    endtask

    task automatic wait_ready(input bit use_n, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((use_n ? ready_n : ready) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        init = 1'b0;
        key = '0;
        keylen = 1'b0;
        round = 4'd0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++;
        if (sboxw !== 32'h0) begin errors++; $display("FAIL reset_sboxw: got %h expected 0", sboxw); end
        checks++;
        if (round_key !== 128'h0) begin errors++; $display("FAIL reset_rk0: got %h expected 0", round_key); end
    endtask

    task automatic test_aes128();
        int lat;
        start(KEY_A1, 1'b0);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 11) begin errors++; $display("FAIL aes128_latency: got %0d expected 11", lat); end
        for (int r = 0; r <= 10; r++) begin
            round = 4'(r);
            #1;
            checks++;
            if (round_key !== A128[r]) begin
                errors++;
                $display("FAIL aes128_round%0d: got %h expected %h", r, round_key, A128[r]);
            end
        end
        round = 4'd11;
        #1;
        checks++;
        if (round_key !== 128'h0) begin errors++; $display("FAIL aes128_round11: got %h expected 0", round_key); end
    endtask

    task automatic test_aes256();
        int lat;
        build_model(KEY_A3, 1'b1);
        start(KEY_A3, 1'b1);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 15) begin errors++; $display("FAIL aes256_latency: got %0d expected 15", lat); end
        round = 4'd0; #1;
        checks++;
        if (round_key !== A256_R0) begin errors++; $display("FAIL aes256_r0: got %h expected %h", round_key, A256_R0); end
        round = 4'd1; #1;
        checks++;
        if (round_key !== A256_R1) begin errors++; $display("FAIL aes256_r1: got %h expected %h", round_key, A256_R1); end
        round = 4'd2; #1;
        checks++;
        if (round_key !== A256_R2) begin errors++; $display("FAIL aes256_r2: got %h expected %h", round_key, A256_R2); end
        round = 4'd14; #1;
        checks++;
        if (round_key !== A256_R14) begin errors++; $display("FAIL aes256_r14: got %h expected %h", round_key, A256_R14); end
        for (int r = 3; r <= 13; r++) begin
            round = 4'(r);
            #1;
            checks++;
            if (round_key !== model_rk[r]) begin
                errors++;
                $display("FAIL aes256_round%0d: got %h expected %h", r, round_key, model_rk[r]);
            end
        end
        round = 4'd15; #1;
        checks++;
        if (round_key !== 128'h0) begin errors++; $display("FAIL aes256_round15: got %h expected 0", round_key); end
    endtask

    task automatic test_reinit();
        int lat;
        start(KEY_A3, 1'b1);
        repeat (4) tick();
        start(KEY_A1, 1'b0);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 11) begin errors++; $display("FAIL reinit_latency: got %0d expected 11", lat); end
        round = 4'd10; #1;
        checks++;
        if (round_key !== A128[10]) begin errors++; $display("FAIL reinit_r10: got %h expected %h", round_key, A128[10]); end
        round = 4'd11; #1;
        checks++;
        if (round_key !== 128'h0) begin errors++; $display("FAIL reinit_r11: got %h expected 0", round_key); end
    endtask

    task automatic test_aes256_disabled();
        int lat;
        start(KEY_A1, 1'b1);
        wait_ready(1'b1, lat);
        checks++;
        if (lat != 11) begin errors++; $display("FAIL dis_latency: got %0d expected 11", lat); end
        round = 4'd1; #1;
        checks++;
        if (round_key_n !== A128[1]) begin errors++; $display("FAIL dis_r1: got %h expected %h", round_key_n, A128[1]); end
        round = 4'd10; #1;
        checks++;
        if (round_key_n !== A128[10]) begin errors++; $display("FAIL dis_r10: got %h expected %h", round_key_n, A128[10]); end
        round = 4'd14; #1;
        checks++;
        if (round_key_n !== 128'h0) begin errors++; $display("FAIL dis_r14: got %h expected 0", round_key_n); end
    endtask

    task automatic test_reset_mid_gen();
        start(KEY_A3, 1'b1);
        repeat (5) tick();
        key = KEY_A1;
        keylen = 1'b0;
        reset_n = 1'b0;
        init = 1'b1;
        tick();
        reset_n = 1'b1;
        init = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
        checks++;
        if (sboxw !== 32'h0) begin errors++; $display("FAIL rstmid_sboxw: got %h expected 0", sboxw); end
        for (int r = 0; r <= 15; r++) begin
            round = 4'(r);
            #0.2;
            checks++;
            if (round_key !== 128'h0) begin
                errors++;
                $display("FAIL rstmid_round%0d: got %h expected 0", r, round_key);
            end
        end
        repeat (12) tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_later: got %b expected 0", ready); end
        round = 4'd0; #1;
        checks++;
        if (round_key !== 128'h0) begin errors++; $display("FAIL rstmid_nowrite: got %h expected 0", round_key); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start(KEY_A1, 1'b0);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 11) begin errors++; $display("FAIL b2b_128_latency: got %0d expected 11", lat); end
        for (int r = 0; r <= 15; r++) begin
            round = 4'(r);
            #0.2;
            checks++;
            if (round_key !== ((r <= 10) ? A128[r] : 128'h0)) begin
                errors++;
                $display("FAIL b2b_128_round%0d: got %h expected %h", r, round_key, (r <= 10) ? A128[r] : 128'h0);
            end
        end
        build_model(KEY_A3, 1'b1);
        start(KEY_A3, 1'b1);
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 15) begin errors++; $display("FAIL b2b_256_latency: got %0d expected 15", lat); end
        for (int r = 0; r <= 15; r++) begin
            round = 4'(r);
            #0.2;
            checks++;
            if (round_key !== ((r <= 14) ? model_rk[r] : 128'h0)) begin
                errors++;
                $display("FAIL b2b_256_round%0d: got %h expected %h", r, round_key, (r <= 14) ? model_rk[r] : 128'h0);
            end
        end
        repeat (3) tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_hold: got %b expected 1", ready); end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes256();
        test_reinit();
        test_aes256_disabled();
        test_reset_mid_gen();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
